uart_tx_arbiter: RTL and testbench

- Shares one UART transmit line among NUM_REQ byte sources.
- Uses round-robin arbitration and serialises each granted byte as an 8N1 frame (LSB first), timed by an external one-cycle baud_tick pulse from the baud generator.
- Sits between the per-channel byte producers and the pad-level tx pin.
- Combines the scheduling of the shared serial resource and the frame sequencing in one block.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the shared UART transmit arbiter.
// The parity state is only entered when UART_TX_ARB_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int   DATA_BITS_DEF = 8;
    localparam logic TX_IDLE       = 1'b1;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin search: first requester after last_i (wrapping) with req set.
// The pointer itself is owned by the caller.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    input  logic               en_i,
    output logic [IDW-1:0]     win_o,
    output logic               found_o
);

    logic [IDW-1:0] idx;
    logic           hit;

    always_comb begin
        idx   = last_i;
        hit   = 1'b0;
        win_o = '0;
        // Explicit wrap so non-power-of-two NUM_REQ never visits a phantom index.
        for (int k = 0; k < NUM_REQ; k++) begin
            if (idx == IDW'(NUM_REQ - 1)) begin
                idx = '0;
            end else begin
                idx = idx + IDW'(1);
            end
            if (en_i && !hit && req_i[idx]) begin
                hit   = 1'b1;
                win_o = idx;
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART tx line among NUM_REQ byte sources, stepped by baud_tick.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = DATA_BITS_DEF,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         baud_tick,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [IDW-1:0]               grant_id
);

    localparam int CNTW = $clog2(DATA_BITS + 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [CNTW-1:0]      cnt_q;
    logic [IDW-1:0]       last_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 tx_q;
    logic                 busy_q;
    logic [IDW-1:0]       gid_q;
`ifdef UART_TX_ARB_PARITY_EN
    logic                 par_q;
`endif

    logic                 arb_en;
    logic                 found;
    logic [IDW-1:0]       win;
    logic [DATA_BITS-1:0] data_arr [NUM_REQ];
    logic [DATA_BITS-1:0] win_data;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    assign win_data = data_arr[win];
    assign arb_en   = baud_tick && ((state_q == IDLE) || (state_q == STOP));

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .last_i  (last_q),
        .en_i    (arb_en),
        .win_o   (win),
        .found_o (found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            ready_q <= '0;
            tx_q    <= TX_IDLE;
            busy_q  <= 1'b0;
            gid_q   <= '0;
`ifdef UART_TX_ARB_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            ready_q <= '0;
            if (baud_tick) begin
                case (state_q)
                    // The final stop tick doubles as an arbitration slot for back-to-back frames.
                    IDLE, STOP: begin
                        if (found) begin
                            ready_q <= NUM_REQ'(1) << win;
                            shift_q <= win_data;
                            gid_q   <= win;
                            last_q  <= win;
                            tx_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= START;
`ifdef UART_TX_ARB_PARITY_EN
                            par_q   <= ^win_data;
`endif
                        end else begin
                            tx_q    <= TX_IDLE;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    START: begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= CNTW'(1);
                        state_q <= DATA;
                    end
                    DATA: begin
                        if (cnt_q == CNTW'(DATA_BITS)) begin
`ifdef UART_TX_ARB_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= TX_IDLE;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            cnt_q   <= cnt_q + CNTW'(1);
                        end
                    end
`ifdef UART_TX_ARB_PARITY_EN
                    PARITY: begin
                        tx_q    <= TX_IDLE;
                        state_q <= STOP;
                    end
`endif
                    default: begin
                        tx_q    <= TX_IDLE;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign grant_id  = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a frame-level model.
// Frame length follows UART_TX_ARB_PARITY_EN.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            baud_tick;
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            tx;
    logic            busy;
    logic [1:0]      grant_id;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a frame is FRAME bit periods; m_pos is the bit period on the line (-1 = idle).
    int            m_pos;
    int            m_last;
    int            m_gid;
    logic [7:0]    m_byte;
    logic [NR-1:0] m_ready;
    int            obs_q[$];
    bit            saw_ready2;

    function automatic logic fbit(input int pos, input logic [7:0] b);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef UART_TX_ARB_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pos   = -1;
        m_last  = NR - 1;
        m_gid   = 0;
        m_byte  = '0;
        m_ready = '0;
    endtask

    task automatic model_step();
        int  w;
        bit  found;
        m_ready = '0;
        if (baud_tick) begin
            if (m_pos < 0 || m_pos == FRAME - 1) begin
                found = 0;
                w     = 0;
                for (int off = 1; off <= NR; off++) begin
                    int i;
                    i = (m_last + off) % NR;
                    if (!found && req_valid[i]) begin
                        found = 1;
                        w     = i;
                    end
                end
                if (found) begin
                    m_ready[w] = 1'b1;
                    m_byte     = req_data[w*8 +: 8];
                    m_gid      = w;
                    m_last     = w;
                    m_pos      = 0;
                end else begin
                    m_pos = -1;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic tick_cycle(input logic t);
        baud_tick = t;
        @(posedge clk);
        model_step();
        #1;
        chk("tx", tx, (m_pos < 0) ? 1'b1 : fbit(m_pos, m_byte));
        chk("busy", busy, m_pos >= 0);
        chk("ready", req_ready, m_ready);
        chk("grant_id", grant_id, m_gid);
        if (req_ready != '0) obs_q.push_back(int'(grant_id));
        if (req_ready[2]) saw_ready2 = 1;
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) tick_cycle(1'b0);
            tick_cycle(1'b1);
        end
    endtask

    task automatic chk_order(input string tag, input int exp[$]);
        chk({tag, "_len"}, obs_q.size(), exp.size());
        for (int k = 0; k < exp.size() && k < obs_q.size(); k++)
            chk(tag, obs_q[k], exp[k]);
    endtask

    int sr_base[9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        rst       = 1'b1;
        baud_tick = 1'b0;
        req_valid = '0;
        req_data  = '0;
        model_reset();
        #12;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_gid", grant_id, 0);
        #11 rst = 1'b0;

        // Single requester 1 with 0xA5
        tick_cycle(1'b0);
        req_valid[1]       = 1'b1;
        req_data[1*8 +: 8] = 8'hA5;
        tick_cycle(1'b1);
        chk("sr_ready", req_ready, 4'b0010);
        chk("sr_gid", grant_id, 1);
        chk("sr_start", tx, 0);
        req_valid[1] = 1'b0;
        tick_cycle(1'b0);
        chk("sr_ready_clr", req_ready, 0);
        for (int k = 1; k < FRAME; k++) begin
            run_ticks(1, 2);
            chk("sr_tx", tx, (k < 9) ? sr_base[k] : ((FRAME == 11 && k == 9) ? 0 : 1));
            chk("sr_busy", busy, 1);
        end
        run_ticks(1, 2);
        chk("sr_idle_tx", tx, 1);
        chk("sr_idle_busy", busy, 0);

        // Reset during data bit 4
        req_valid[1]       = 1'b1;
        req_data[1*8 +: 8] = 8'h3C;
        run_ticks(1, 1);
        req_valid[1] = 1'b0;
        run_ticks(5, 1);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gid", grant_id, 0);
        #2 rst = 1'b0;

        // All four continuously valid; consecutive ticks
        for (int i = 0; i < NR; i++) req_data[i*8 +: 8] = 8'(i);
        req_valid = '1;
        obs_q.delete();
        run_ticks(1 + 4 * FRAME, 0);
        req_valid = '0;
        run_ticks(FRAME, 1);
        chk_order("rr_order", '{0, 1, 2, 3, 0});

        // Requester 2 drops before its turn
        obs_q.delete();
        saw_ready2 = 0;
        req_data   = 32'h33_22_11_00;
        req_valid  = 4'b1110;
        run_ticks(1, 1);
        req_valid[1] = 1'b0;
        run_ticks(3, 2);
        req_valid[2] = 1'b0;
        run_ticks(FRAME - 3, 2);
        req_valid[3] = 1'b0;
        run_ticks(FRAME, 1);
        chk_order("skip_order", '{1, 3});
        chk("skip_no_ready2", saw_ready2, 0);

        // Valid raised between ticks
        req_valid[0]       = 1'b1;
        req_data[0*8 +: 8] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            tick_cycle(1'b0);
            chk("bt_no_ready", req_ready, 0);
            chk("bt_tx_idle", tx, 1);
        end
        tick_cycle(1'b1);
        chk("bt_ready", req_ready, 4'b0001);
        chk("bt_gid", grant_id, 0);
        req_valid[0] = 1'b0;
        run_ticks(FRAME, 1);

`ifdef UART_TX_ARB_PARITY_EN
        req_valid[0]       = 1'b1;
        req_data[0*8 +: 8] = 8'h07;
        run_ticks(1, 1);
        req_valid[0] = 1'b0;
        run_ticks(9, 1);
        chk("par07", tx, 1);
        run_ticks(1, 1);
        chk("par07_stop", tx, 1);
        run_ticks(1, 1);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick_cycle($urandom_range(0, 2) == 0);
            for (int i = 0; i < NR; i++) begin
                if (m_ready[i]) begin
                    req_valid[i]       = 1'($urandom_range(0, 1));
                    req_data[i*8 +: 8] = 8'($urandom);
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        req_valid[i]       = 1'b1;
                        req_data[i*8 +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
